data_sync_tx: RTL and testbench

- Source-domain launcher for the bus synchronizer: captures one word from a local valid/ready producer and drives `Unsync_bus`/`Unsync_enable` toward the destination-domain synchronizer.
- Full 4-phase req/ack handshake: `Unsync_bus` is held stable from enable rise until the destination's ack has been seen low again.
- The destination returns ack as a level; this block synchronizes it internally.
- Single clock domain (source side).

---
 rtl/dsync_pkg.sv | 17 +
 rtl/bit_sync.sv | 30 +++
 rtl/data_sync_tx.sv | 150 +++++++++++++++
 tb/tb_data_sync_tx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dsync_pkg.sv
// Shared definitions for the bus-synchronizer launch path.
// Contents: FSM state type and encoding width, default word width and
// default depth of the ack synchronizer.
package dsync_pkg;

  localparam int STATE_W        = 2;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_N_STAGES   = 2;

  // Encoding is fixed so that 2'b11 is the one illegal value.
  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    RELEASE = 2'b10
  } dsync_state_e;

endpackage : dsync_pkg

// File: rtl/bit_sync.sv
// Multi-flop level synchronizer for a single bit. It is also used on the
// destination side.
// Ports:
//   clk      - destination clock of the synchronized level
//   rst      - synchronous, active-high reset; clears every stage
//   async_in - level from another clock domain
//   sync_out - synchronized level, N_STAGES edges behind async_in
module bit_sync #(
  parameter int N_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic [N_STAGES-1:0] sync_r;

  // Shift the incoming level through the synchronizer chain
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {N_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[N_STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_r[N_STAGES-1];

endmodule : bit_sync

// File: rtl/data_sync_tx.sv
// Source-domain launcher for the bus synchronizer. It takes one word from
// a valid/ready producer, holds it on Unsync_bus and runs a 4-phase
// req/ack handshake through Unsync_enable and the returned ack level.
// Optional feature macro DSTX_TIMEOUT_EN: each handshake phase is bounded
// by TIMEOUT_CYCLES, and timeout_err is set (sticky) when a phase runs out.
// Ports:
//   D_CLK, D_RST  - source clock, synchronous active-high reset
//   src_data/src_valid/src_ready - producer interface
//   ack_async     - unsynchronized ack level from the destination
//   Unsync_bus    - held word toward the destination synchronizer
//   Unsync_enable - request level toward the destination synchronizer
//   busy          - handshake in progress
//   timeout_err   - sticky timeout flag (tied 0 without DSTX_TIMEOUT_EN)
module data_sync_tx
  import dsync_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_STAGES   = DEF_N_STAGES
`ifdef DSTX_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                  D_CLK,
  input  logic                  D_RST,
  input  logic [DATA_WIDTH-1:0] src_data,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic                  ack_async,
  output logic [DATA_WIDTH-1:0] Unsync_bus,
  output logic                  Unsync_enable,
  output logic                  busy,
  output logic                  timeout_err
);

  dsync_state_e          state_r;
  dsync_state_e          nxt_state_s;
  logic [DATA_WIDTH-1:0] bus_r;
  logic                  en_r;
  logic                  en_nxt_s;
  logic                  load_s;
  logic                  ack_s;
  logic                  src_ready_s;
  logic                  accept_s;
  logic                  timeout_hit_s;

  bit_sync #(
    .N_STAGES (N_STAGES)
  ) u_ack_sync (
    .clk      (D_CLK),
    .rst      (D_RST),
    .async_in (ack_async),
    .sync_out (ack_s)
  );

  // A stale ack still high from a previous handshake blocks new launches.
  assign src_ready_s = (state_r == IDLE) && !ack_s && !D_RST;
  assign accept_s    = src_valid && src_ready_s;

  // State register plus the registered bus/enable outputs
  always_ff @(posedge D_CLK) begin
    if (D_RST) begin
      state_r <= IDLE;
      bus_r   <= {DATA_WIDTH{1'b0}};
      en_r    <= 1'b0;
    end else begin
      state_r <= nxt_state_s;
      en_r    <= en_nxt_s;
      if (load_s) begin
        bus_r <= src_data;
      end else begin
        bus_r <= bus_r;
      end
    end
  end

  // Next-state logic of the 4-phase handshake
  always_comb begin
    nxt_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) nxt_state_s = REQ;
        else          nxt_state_s = IDLE;
      end
      REQ: begin
        if (timeout_hit_s) nxt_state_s = IDLE;
        else if (ack_s)    nxt_state_s = RELEASE;
        else               nxt_state_s = REQ;
      end
      RELEASE: begin
        if (timeout_hit_s) nxt_state_s = IDLE;
        else if (!ack_s)   nxt_state_s = IDLE;
        else               nxt_state_s = RELEASE;
      end
      default: nxt_state_s = IDLE;
    endcase
  end

  // Output decode: request is high exactly while the next state is REQ
  always_comb begin
    en_nxt_s = 1'b0;
    load_s   = 1'b0;
    if (nxt_state_s == REQ) en_nxt_s = 1'b1;
    else                    en_nxt_s = 1'b0;
    if (accept_s) load_s = 1'b1;
    else          load_s = 1'b0;
  end

`ifdef DSTX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_r;
  logic             err_r;

  // Abort fires on the edge where the phase counter reaches TIMEOUT_CYCLES.
  assign timeout_hit_s = (state_r != IDLE) &&
                         (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Per-phase counter and sticky timeout flag
  always_ff @(posedge D_CLK) begin
    if (D_RST) begin
      cnt_r <= {CNT_W{1'b0}};
      err_r <= 1'b0;
    end else begin
      if (nxt_state_s != state_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (state_r != IDLE) begin
        cnt_r <= cnt_r + 1'b1;
      end else begin
        cnt_r <= {CNT_W{1'b0}};
      end
      if (timeout_hit_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign timeout_err = err_r;
`else
  assign timeout_hit_s = 1'b0;
  assign timeout_err   = 1'b0;
`endif

  assign src_ready     = src_ready_s;
  assign Unsync_bus    = bus_r;
  assign Unsync_enable = en_r;
  assign busy          = (state_r != IDLE);

endmodule : data_sync_tx

// File: tb/tb_data_sync_tx.sv
// Directed bench for data_sync_tx (DATA_WIDTH=8, N_STAGES=2). Inputs are
// driven 1 time unit after the rising edge; outputs are checked there.
module tb_data_sync_tx;

  localparam int DW = 8;
  localparam int NS = 2;

  logic          D_CLK = 1'b0;
  logic          D_RST;
  logic [DW-1:0] src_data;
  logic          src_valid;
  logic          src_ready;
  logic          ack_async;
  logic [DW-1:0] Unsync_bus;
  logic          Unsync_enable;
  logic          busy;
  logic          timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 D_CLK = ~D_CLK;

  data_sync_tx #(
    .DATA_WIDTH (DW),
    .N_STAGES   (NS)
`ifdef DSTX_TIMEOUT_EN
    , .TIMEOUT_CYCLES (8)
`endif
  ) dut (
    .D_CLK         (D_CLK),
    .D_RST         (D_RST),
    .src_data      (src_data),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .ack_async     (ack_async),
    .Unsync_bus    (Unsync_bus),
    .Unsync_enable (Unsync_enable),
    .busy          (busy),
    .timeout_err   (timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge D_CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] launch [4];
    int            nl;
    logic          prev_en;

    // ---- reset ----
    D_RST = 1'b1; src_valid = 1'b0; src_data = 8'h00; ack_async = 1'b0;
    tick(); tick();
    check("rst_bus",   32'(Unsync_bus),    32'h00);
    check("rst_en",    32'(Unsync_enable), 32'd0);
    check("rst_busy",  32'(busy),          32'd0);
    check("rst_ready", 32'(src_ready),     32'd0);
    check("rst_err",   32'(timeout_err),   32'd0);
    D_RST = 1'b0;
    #1;
    check("rel_ready", 32'(src_ready), 32'd1);

    // ---- single transfer ----
    src_data = 8'hAA; src_valid = 1'b1;
    tick();
    src_valid = 1'b0; src_data = 8'h55;
    check("t2_bus",   32'(Unsync_bus),    32'hAA);
    check("t2_en",    32'(Unsync_enable), 32'd1);
    check("t2_busy",  32'(busy),          32'd1);
    check("t2_ready", 32'(src_ready),     32'd0);
    ack_async = 1'b1;
    for (int i = 1; i <= NS + 1; i++) begin
      tick();
      check("t2_en_ack", 32'(Unsync_enable), (i <= NS) ? 32'd1 : 32'd0);
    end
    check("t2_bus_rel", 32'(Unsync_bus), 32'hAA);
    ack_async = 1'b0;
    for (int i = 1; i <= NS + 1; i++) begin
      tick();
      check("t2_ready_rel", 32'(src_ready), (i == NS + 1) ? 32'd1 : 32'd0);
    end
    check("t2_bus_idle",  32'(Unsync_bus), 32'hAA);
    check("t2_busy_idle", 32'(busy),       32'd0);

    // ---- back-to-back with a level-following destination ----
    nl = 0;
    prev_en = Unsync_enable;
    src_data = 8'h01; src_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (Unsync_enable && !prev_en) begin
        if (nl < 4) launch[nl] = Unsync_bus;
        nl++;
        if (nl == 1) src_data = 8'hFE;
        else         src_valid = 1'b0;
      end
      prev_en   = Unsync_enable;
      ack_async = Unsync_enable;
    end
    check("t3_count",   32'(nl),         32'd2);
    check("t3_first",   32'(launch[0]),  32'h01);
    check("t3_second",  32'(launch[1]),  32'hFE);
    check("t3_bus_end", 32'(Unsync_bus), 32'hFE);
    check("t3_busy",    32'(busy),       32'd0);

    // ---- stale ack held from reset release ----
    D_RST = 1'b1; ack_async = 1'b1; src_valid = 1'b0;
    tick(); tick();
    D_RST = 1'b0;
    // the synchronizer needs NS edges to show the held ack
    for (int i = 0; i < NS; i++) tick();
    check("t4_ready_stale", 32'(src_ready), 32'd0);
    src_data = 8'h33; src_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t4_no_launch", 32'(Unsync_enable), 32'd0);
    end
    check("t4_bus", 32'(Unsync_bus), 32'h00);
    ack_async = 1'b0;
    // in IDLE, ready follows the synchronized ack directly
    for (int i = 1; i <= NS; i++) begin
      tick();
      check("t4_ready_rel", 32'(src_ready), (i == NS) ? 32'd1 : 32'd0);
    end
    tick();
    check("t4_launch_en",  32'(Unsync_enable), 32'd1);
    check("t4_launch_bus", 32'(Unsync_bus),    32'h33);
    src_valid = 1'b0;

    // ---- reset in the middle of REQ ----
    D_RST = 1'b1;
    tick();
    check("t5_en",   32'(Unsync_enable), 32'd0);
    check("t5_bus",  32'(Unsync_bus),    32'h00);
    check("t5_busy", 32'(busy),          32'd0);
    D_RST = 1'b0;
    tick();
    check("t5_ready", 32'(src_ready), 32'd1);

`ifdef DSTX_TIMEOUT_EN
    // ---- timeout with no ack, then a normal transfer ----
    src_data = 8'hC3; src_valid = 1'b1;
    tick();
    src_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("t6_en_wait", 32'(Unsync_enable), (i < 8) ? 32'd1 : 32'd0);
    end
    check("t6_err",  32'(timeout_err), 32'd1);
    check("t6_busy", 32'(busy),        32'd0);
    src_data = 8'h5A; src_valid = 1'b1;
    tick();
    src_valid = 1'b0;
    ack_async = 1'b1;
    for (int i = 0; i < NS + 1; i++) tick();
    ack_async = 1'b0;
    for (int i = 0; i < NS + 1; i++) tick();
    check("t6_bus2",   32'(Unsync_bus),  32'h5A);
    check("t6_busy2",  32'(busy),        32'd0);
    check("t6_sticky", 32'(timeout_err), 32'd1);
`else
    check("t6_err_off", 32'(timeout_err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_data_sync_tx
